// File: rtl/s_term_loopback_matrix.sv
`default_nettype none
// ============================================================================
// Module   : s_term_loopback_matrix
// Purpose  : South-terminal loopback matrix for the bottom edge of a column.
//            Every southbound wire class is returned northbound with its index
//            reversed. Each returned wire has its own 2-bit mode:
//              00 combinational pass, 01 registered (1 stage),
//              10 constant 0,         11 constant 1.
//            Modes are loaded serially into a shadow chain and copied into
//            the active set by a single-cycle commit pulse.
// Ports    : UserCLK      - fabric user clock, rising edge
//            RESETn       - asynchronous active-low reset
//            S1END/S2MID/S2END/S4END/SS4END - southbound inputs
//            N1BEG/N2BEG/N2BEGb/N4BEG/NN4BEG - returned northbound outputs
//            cfg_shift_en - shift the shadow chain one bit
//            cfg_data_in  - serial configuration bit (enters the top)
//            cfg_commit   - copy shadow into the active modes
//            cfg_data_out - shadow[0], for daisy-chaining
// Revision : 1.0 - initial release
// ============================================================================
module s_term_loopback_matrix #(
  parameter int W1  = 4,
  parameter int W2  = 8,
  parameter int W4  = 16,
  parameter int WW4 = 16
) (
  input  logic            UserCLK,
  input  logic            RESETn,
  input  logic [W1-1:0]   S1END,
  input  logic [W2-1:0]   S2MID,
  input  logic [W2-1:0]   S2END,
  input  logic [W4-1:0]   S4END,
  input  logic [WW4-1:0]  SS4END,
  output logic [W1-1:0]   N1BEG,
  output logic [W2-1:0]   N2BEG,
  output logic [W2-1:0]   N2BEGb,
  output logic [W4-1:0]   N4BEG,
  output logic [WW4-1:0]  NN4BEG,
  input  logic            cfg_shift_en,
  input  logic            cfg_data_in,
  input  logic            cfg_commit,
  output logic            cfg_data_out
);

  // Flat layout: singles, doubles (mid), doubles (end), quads, long quads.
  localparam int c_T      = W1 + 2*W2 + W4 + WW4;
  localparam int c_C      = 2 * c_T;
  localparam int c_OFF_2M = W1;
  localparam int c_OFF_2E = W1 + W2;
  localparam int c_OFF_4  = W1 + 2*W2;
  localparam int c_OFF_W4 = W1 + 2*W2 + W4;

  logic [c_T-1:0] w_src;
  logic [c_T-1:0] w_out;
  logic [c_T-1:0] r_pipe;
  logic [c_C-1:0] r_shadow;
  logic [c_C-1:0] r_active;

  // --------------------------------------------------------------------------
  // Index-reversed source selection, flattened in output order
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < W1; i++) begin : g_src1
    assign w_src[i] = S1END[W1-1-i];
  end
  for (genvar i = 0; i < W2; i++) begin : g_src2
    assign w_src[c_OFF_2M+i] = S2MID[W2-1-i];
    assign w_src[c_OFF_2E+i] = S2END[W2-1-i];
  end
  for (genvar i = 0; i < W4; i++) begin : g_src4
    assign w_src[c_OFF_4+i] = S4END[W4-1-i];
  end
  for (genvar i = 0; i < WW4; i++) begin : g_srcw4
    assign w_src[c_OFF_W4+i] = SS4END[WW4-1-i];
  end

  // --------------------------------------------------------------------------
  // Pipeline flops capture unconditionally so that a switch to registered
  // mode delivers valid data on the very first cycle.
  // Commit samples the shadow before this edge's shift, so a simultaneous
  // shift+commit loads the pre-shift value.
  // --------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pipe   <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      r_pipe <= w_src;
      if (cfg_shift_en) begin
        r_shadow <= {cfg_data_in, r_shadow[c_C-1:1]};
      end
      if (cfg_commit) begin
        r_active <= r_shadow;
      end
    end
  end

  assign cfg_data_out = r_shadow[0];

  // --------------------------------------------------------------------------
  // Per-output mode multiplexer
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < c_T; j++) begin : g_out
    logic [1:0] w_mode;
    assign w_mode = r_active[2*j+1 -: 2];

    always_comb begin
      w_out[j] = w_src[j];
      case (w_mode)
        2'b00:   w_out[j] = w_src[j];
        2'b01:   w_out[j] = r_pipe[j];
        2'b10:   w_out[j] = 1'b0;
        default: w_out[j] = 1'b1;
      endcase
    end
  end

  assign N1BEG  = w_out[c_OFF_2M-1:0];
  assign N2BEG  = w_out[c_OFF_2E-1:c_OFF_2M];
  assign N2BEGb = w_out[c_OFF_4-1:c_OFF_2E];
  assign N4BEG  = w_out[c_OFF_W4-1:c_OFF_4];
  assign NN4BEG = w_out[c_T-1:c_OFF_W4];

endmodule
`default_nettype wire

// File: tb/tb_s_term_loopback_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_term_loopback_matrix
// Purpose  : Directed self-checking bench for s_term_loopback_matrix at
//            default parameters (T = 52 outputs, 104-bit config chain).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_term_loopback_matrix;

  localparam int W1  = 4;
  localparam int W2  = 8;
  localparam int W4  = 16;
  localparam int WW4 = 16;
  localparam int C   = 104;

  logic            UserCLK;
  logic            RESETn;
  logic            clk_en;
  logic [W1-1:0]   S1END;
  logic [W2-1:0]   S2MID;
  logic [W2-1:0]   S2END;
  logic [W4-1:0]   S4END;
  logic [WW4-1:0]  SS4END;
  logic [W1-1:0]   N1BEG;
  logic [W2-1:0]   N2BEG;
  logic [W2-1:0]   N2BEGb;
  logic [W4-1:0]   N4BEG;
  logic [WW4-1:0]  NN4BEG;
  logic            cfg_shift_en;
  logic            cfg_data_in;
  logic            cfg_commit;
  logic            cfg_data_out;

  int checks = 0;
  int errors = 0;

  s_term_loopback_matrix #(
    .W1(W1), .W2(W2), .W4(W4), .WW4(WW4)
  ) dut (
    .UserCLK      (UserCLK),
    .RESETn       (RESETn),
    .S1END        (S1END),
    .S2MID        (S2MID),
    .S2END        (S2END),
    .S4END        (S4END),
    .SS4END       (SS4END),
    .N1BEG        (N1BEG),
    .N2BEG        (N2BEG),
    .N2BEGb       (N2BEGb),
    .N4BEG        (N4BEG),
    .NN4BEG       (NN4BEG),
    .cfg_shift_en (cfg_shift_en),
    .cfg_data_in  (cfg_data_in),
    .cfg_commit   (cfg_commit),
    .cfg_data_out (cfg_data_out)
  );

  initial UserCLK = 1'b0;
  always begin
    #5;
    if (clk_en) UserCLK = ~UserCLK;
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic shift_vec(input logic [C-1:0] v);
    for (int i = 0; i < C; i++) begin
      cfg_shift_en = 1'b1;
      cfg_data_in  = v[i];
      @(posedge UserCLK); #1;
    end
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    @(posedge UserCLK); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    RESETn = 1'b0;
    cfg_shift_en = 1'b0; cfg_data_in = 1'b0; cfg_commit = 1'b0;
    S1END  = 4'b0001;
    S2MID  = 8'h01;
    S2END  = 8'h03;
    S4END  = 16'h8001;
    SS4END = 16'h00F0;
    #3;
    checks++; if (N1BEG !== 4'b1000) begin errors++; $display("FAIL reset_n1: got %h want %h", N1BEG, 4'b1000); end
    checks++; if (N4BEG !== 16'h8001) begin errors++; $display("FAIL reset_n4: got %h want %h", N4BEG, 16'h8001); end
    checks++; if (N2BEG !== 8'h80) begin errors++; $display("FAIL reset_n2: got %h want %h", N2BEG, 8'h80); end
    checks++; if (N2BEGb !== 8'hC0) begin errors++; $display("FAIL reset_n2b: got %h want %h", N2BEGb, 8'hC0); end
    checks++; if (NN4BEG !== 16'h0F00) begin errors++; $display("FAIL reset_nn4: got %h want %h", NN4BEG, 16'h0F00); end
    checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL reset_cdo: got %b want 0", cfg_data_out); end
    #4;
    RESETn = 1'b1;
    clk_en = 1'b1;
    @(posedge UserCLK); #1;
  endtask

  task automatic test_registered();
    logic [C-1:0] v;
    v = '0;
    v[0] = 1'b1;                 // active[1:0] = 01
    shift_vec(v);
    do_commit();
    S1END = 4'b0000;
    S4END = 16'h0000;
    @(posedge UserCLK); #1;
    checks++; if (N1BEG !== 4'b0000) begin errors++; $display("FAIL reg_idle: got %b want 0000", N1BEG); end
    // S1END[3] rises; other bits also move to show they stay combinational.
    S1END = 4'b1010;
    S4END = 16'h0001;
    #1;
    checks++; if (N1BEG !== 4'b0100) begin errors++; $display("FAIL reg_before_edge: got %b want 0100", N1BEG); end
    checks++; if (N4BEG !== 16'h8000) begin errors++; $display("FAIL reg_n4_comb: got %h want 8000", N4BEG); end
    @(posedge UserCLK); #1;
    checks++; if (N1BEG !== 4'b0101) begin errors++; $display("FAIL reg_after_edge: got %b want 0101", N1BEG); end
    S1END = 4'b0000;
    #1;
    checks++; if (N1BEG !== 4'b0001) begin errors++; $display("FAIL reg_fall_hold: got %b want 0001", N1BEG); end
    @(posedge UserCLK); #1;
    checks++; if (N1BEG !== 4'b0000) begin errors++; $display("FAIL reg_fall_edge: got %b want 0000", N1BEG); end
  endtask

  task automatic test_constants();
    logic [51:0] o;
    shift_vec({C{1'b1}});
    do_commit();
    for (int k = 0; k < 3; k++) begin
      S1END = 4'($urandom); S2MID = 8'($urandom); S2END = 8'($urandom);
      S4END = 16'($urandom); SS4END = 16'($urandom);
      @(posedge UserCLK); #1;
      o = {NN4BEG, N4BEG, N2BEGb, N2BEG, N1BEG};
      checks++; if (o !== {52{1'b1}}) begin errors++; $display("FAIL const_ones: got %h want all ones", o); end
    end
    shift_vec({52{2'b10}});
    do_commit();
    for (int k = 0; k < 3; k++) begin
      S1END = 4'($urandom); S2MID = 8'($urandom); S2END = 8'($urandom);
      S4END = 16'($urandom); SS4END = 16'($urandom);
      @(posedge UserCLK); #1;
      o = {NN4BEG, N4BEG, N2BEGb, N2BEG, N1BEG};
      checks++; if (o !== 52'h0) begin errors++; $display("FAIL const_zeros: got %h want 0", o); end
    end
  endtask

  task automatic test_shadow_isolation();
    logic exp_bit;
    shift_vec({52{2'b01}});
    do_commit();
    S4END = 16'h0000;
    @(posedge UserCLK); #1;
    // Old shadow is {52{2'b01}}: even bits 1, odd bits 0.
    for (int m = 0; m < C; m++) begin
      exp_bit = (m % 2 == 0);
      checks++; if (cfg_data_out !== exp_bit) begin errors++; $display("FAIL iso_cdo_%0d: got %b want %b", m, cfg_data_out, exp_bit); end
      cfg_shift_en = 1'b1;
      cfg_data_in  = 1'b1;
      @(posedge UserCLK); #1;
    end
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    checks++; if (cfg_data_out !== 1'b1) begin errors++; $display("FAIL iso_first_new: got %b want 1", cfg_data_out); end
    // Routing must still be registered (no commit happened).
    S4END = 16'h1234;
    #1;
    checks++; if (N4BEG !== 16'h0000) begin errors++; $display("FAIL iso_hold: got %h want 0000", N4BEG); end
    @(posedge UserCLK); #1;
    checks++; if (N4BEG !== 16'h2C48) begin errors++; $display("FAIL iso_reg: got %h want 2c48", N4BEG); end
  endtask

  task automatic test_shift_commit();
    logic [51:0] o;
    S1END = '1; S2MID = '1; S2END = '1; S4END = '1; SS4END = '1;
    shift_vec({52{2'b10}});
    cfg_shift_en = 1'b1;
    cfg_data_in  = 1'b1;
    cfg_commit   = 1'b1;
    @(posedge UserCLK); #1;
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    cfg_commit   = 1'b0;
    o = {NN4BEG, N4BEG, N2BEGb, N2BEG, N1BEG};
    checks++; if (o !== 52'h0) begin errors++; $display("FAIL sc_modes: got %h want 0", o); end
    checks++; if (cfg_data_out !== 1'b1) begin errors++; $display("FAIL sc_cdo0: got %b want 1", cfg_data_out); end
    for (int m = 1; m <= 104; m++) begin
      cfg_shift_en = 1'b1;
      cfg_data_in  = 1'b0;
      @(posedge UserCLK); #1;
      if (m == 102) begin
        checks++; if (cfg_data_out !== 1'b1) begin errors++; $display("FAIL sc_cdo102: got %b want 1", cfg_data_out); end
      end
      if (m == 103) begin
        checks++; if (cfg_data_out !== 1'b1) begin errors++; $display("FAIL sc_newbit: got %b want 1", cfg_data_out); end
      end
      if (m == 104) begin
        checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL sc_after_new: got %b want 0", cfg_data_out); end
      end
    end
    cfg_shift_en = 1'b0;
  endtask

  task automatic test_reset_midload();
    S1END = 4'b0011; S2MID = 8'h0F; S2END = 8'h12; S4END = 16'h1234; SS4END = 16'h00FF;
    for (int m = 0; m < 50; m++) begin
      cfg_shift_en = 1'b1;
      cfg_data_in  = 1'b1;
      @(posedge UserCLK); #1;
    end
    cfg_shift_en = 1'b0;
    cfg_data_in  = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    checks++; if (N1BEG !== 4'b1100) begin errors++; $display("FAIL rm_async_n1: got %b want 1100", N1BEG); end
    #2 RESETn = 1'b1;
    // Without the reset the 50 ones would reach shadow[0] within 60 shifts.
    for (int m = 0; m < 60; m++) begin
      cfg_shift_en = 1'b1;
      @(posedge UserCLK); #1;
      checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL rm_cdo_%0d: got %b want 0", m, cfg_data_out); end
    end
    cfg_shift_en = 1'b0;
    do_commit();
    checks++; if (N1BEG !== 4'b1100) begin errors++; $display("FAIL rm_n1: got %b want 1100", N1BEG); end
    checks++; if (N2BEG !== 8'hF0) begin errors++; $display("FAIL rm_n2: got %h want f0", N2BEG); end
    checks++; if (N2BEGb !== 8'h48) begin errors++; $display("FAIL rm_n2b: got %h want 48", N2BEGb); end
    checks++; if (N4BEG !== 16'h2C48) begin errors++; $display("FAIL rm_n4: got %h want 2c48", N4BEG); end
    checks++; if (NN4BEG !== 16'hFF00) begin errors++; $display("FAIL rm_nn4: got %h want ff00", NN4BEG); end
    checks++; if (cfg_data_out !== 1'b0) begin errors++; $display("FAIL rm_cdo: got %b want 0", cfg_data_out); end
    // Zero-latency pass-through after the commit.
    S4END = 16'h8000;
    #1;
    checks++; if (N4BEG !== 16'h0001) begin errors++; $display("FAIL rm_comb: got %h want 0001", N4BEG); end
  endtask

  initial begin
    test_reset();
    test_registered();
    test_constants();
    test_shadow_isolation();
    test_shift_commit();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
